// File: rtl/note_match_pkg.sv
// Shared types and constants for the per-note timing matcher.
package note_match_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } chan_state_e;

   localparam int DEF_TIME_W = 16;
   localparam int DEF_WINDOW = 2;

   // Metadata value that marks end of song; truncated to TIME_W where used.
   localparam logic [63:0] END_OF_SONG = '1;

endpackage

// File: rtl/note_match_array_if.sv
// Bus between the note matcher, the detection front end, the metadata store and scoring.
interface note_match_array_if
   import note_match_pkg::*;
#(
   parameter int NUM_NOTES = 37,
   parameter int TIME_W    = DEF_TIME_W
);
   logic [TIME_W-1:0]               song_time;
   logic [NUM_NOTES-1:0]            NDATA;
   logic [NUM_NOTES*TIME_W-1:0]     metadata_link;
   logic [NUM_NOTES-1:0]            metadata_valid;
   logic [NUM_NOTES-1:0]            metadata_request;
   logic [NUM_NOTES-1:0]            match_trigger;
   logic [NUM_NOTES*(TIME_W+1)-1:0] match_time;
   logic [NUM_NOTES-1:0]            miss_trigger;

   modport master (
      output song_time, NDATA, metadata_link, metadata_valid,
      input  metadata_request, match_trigger, match_time, miss_trigger
   );

   modport slave (
      input  song_time, NDATA, metadata_link, metadata_valid,
      output metadata_request, match_trigger, match_time, miss_trigger
   );
endinterface

// File: rtl/note_match_channel.sv
// One note channel: metadata fetch FSM, onset detector and window comparator.
// Miss detection is present only when NOTE_MATCH_MISS_EN is defined.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_FETCH | requesting next expected hit time
//   ST_ARMED | holding expected time, grading onsets
//   ST_DONE  | end-of-song marker received, channel idle
module note_match_channel
   import note_match_pkg::*;
#(
   parameter int TIME_W = DEF_TIME_W,
   parameter int WINDOW = DEF_WINDOW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TIME_W-1:0] song_time,
   input  logic              ndata,
   input  logic [TIME_W-1:0] meta_time,
   input  logic              meta_valid,
   output logic              meta_request,
   output logic              match_trigger,
   output logic [TIME_W:0]   match_time,
   output logic              miss_trigger
);

   localparam logic [TIME_W-1:0]   EOS = END_OF_SONG[TIME_W-1:0];
   localparam logic signed [TIME_W:0] WIN = (TIME_W+1)'(WINDOW);

   chan_state_e       state_q, state_d;
   logic [TIME_W-1:0] expected_q, expected_d;
   logic              ndata_prev_q, ndata_prev_d;
   logic              match_trigger_q, match_trigger_d;
   logic [TIME_W:0]   match_time_q, match_time_d;
   logic signed [TIME_W:0] delta;
   logic              onset;
   logic              in_window;

   // Zero-extended subtract keeps the full unsigned range representable as signed.
   assign delta     = $signed({1'b0, song_time} - {1'b0, expected_q});
   assign in_window = (delta >= -WIN) && (delta <= WIN);
   assign onset     = ndata && !ndata_prev_q;
   assign ndata_prev_d = ndata;

`ifdef NOTE_MATCH_MISS_EN
   logic miss_trigger_q, miss_trigger_d;
   logic late;
   assign late = (delta > WIN);
`endif

   always_comb begin
      state_d         = state_q;
      expected_d      = expected_q;
      match_trigger_d = 1'b0;
      match_time_d    = match_time_q;
`ifdef NOTE_MATCH_MISS_EN
      miss_trigger_d  = 1'b0;
`endif
      case (state_q)
         ST_FETCH: begin
            if (meta_valid) begin
               if (meta_time == EOS) begin
                  state_d = ST_DONE;
               end else begin
                  expected_d = meta_time;
                  state_d    = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (onset && in_window) begin
               match_trigger_d = 1'b1;
               match_time_d    = delta;
               state_d         = ST_FETCH;
            end
`ifdef NOTE_MATCH_MISS_EN
            else if (late) begin
               miss_trigger_d = 1'b1;
               state_d        = ST_FETCH;
            end
`endif
         end
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_FETCH;
         expected_q      <= '0;
         ndata_prev_q    <= 1'b0;
         match_trigger_q <= 1'b0;
         match_time_q    <= '0;
`ifdef NOTE_MATCH_MISS_EN
         miss_trigger_q  <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         expected_q      <= expected_d;
         ndata_prev_q    <= ndata_prev_d;
         match_trigger_q <= match_trigger_d;
         match_time_q    <= match_time_d;
`ifdef NOTE_MATCH_MISS_EN
         miss_trigger_q  <= miss_trigger_d;
`endif
      end
   end

   assign meta_request  = (state_q == ST_FETCH);
   assign match_trigger = match_trigger_q;
   assign match_time    = match_time_q;
`ifdef NOTE_MATCH_MISS_EN
   assign miss_trigger  = miss_trigger_q;
`else
   assign miss_trigger  = 1'b0;
`endif

endmodule

// File: rtl/note_match_array.sv
// Per-note timing matcher: NUM_NOTES independent channels sliced out of the shared bus.
// Optional miss detection is enabled by defining NOTE_MATCH_MISS_EN.
module note_match_array
   import note_match_pkg::*;
#(
   parameter int NUM_NOTES = 37,
   parameter int TIME_W    = DEF_TIME_W,
   parameter int WINDOW    = DEF_WINDOW
) (
   input  logic              clk,
   input  logic              reset,
   note_match_array_if.slave bus
);

   logic [NUM_NOTES-1:0]            req;
   logic [NUM_NOTES-1:0]            hit;
   logic [NUM_NOTES-1:0]            miss;
   logic [NUM_NOTES*(TIME_W+1)-1:0] mtime;

   for (genvar i = 0; i < NUM_NOTES; i++) begin : g_ch
      note_match_channel #(
         .TIME_W (TIME_W),
         .WINDOW (WINDOW)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .song_time     (bus.song_time),
         .ndata         (bus.NDATA[i]),
         .meta_time     (bus.metadata_link[i*TIME_W +: TIME_W]),
         .meta_valid    (bus.metadata_valid[i]),
         .meta_request  (req[i]),
         .match_trigger (hit[i]),
         .match_time    (mtime[i*(TIME_W+1) +: TIME_W+1]),
         .miss_trigger  (miss[i])
      );
   end

   assign bus.metadata_request = req;
   assign bus.match_trigger    = hit;
   assign bus.match_time       = mtime;
   assign bus.miss_trigger     = miss;

endmodule

// File: tb/tb_note_match_array.sv
// Scoreboard bench for note_match_array: directed scenarios, then random stimulus vs a behavioural model.
module tb_note_match_array;
   localparam int N  = 37;
   localparam int TW = 16;
   localparam int W  = 2;
   localparam int MW = TW + 1;

   typedef struct {
      int cyc;
      int ch;
      bit is_miss;
   } ev_t;

   typedef struct {
      int             cyc;
      logic [N-1:0]   req;
      logic [N*MW-1:0] mtime;
   } cyc_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   note_match_array_if #(.NUM_NOTES(N), .TIME_W(TW)) bus ();

   note_match_array #(.NUM_NOTES(N), .TIME_W(TW), .WINDOW(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ev_t  ev_q[$];
   cyc_t cyc_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_no = 0;

   // Behavioural model: 0 = waiting for metadata, 1 = armed, 2 = song over
   int mode[N];
   int exp_t[N];
   bit prev[N];
   int mt[N];

   always @(posedge clk) edge_no <= edge_no + 1;

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         mode[c] = 0; exp_t[c] = 0; prev[c] = 1'b0; mt[c] = 0;
      end
   endfunction

   task automatic chk(input string nm, input logic [N*MW-1:0] act, input logic [N*MW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", nm, act, req);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_request", {{(N*MW-N){1'b0}}, bus.metadata_request}, {{(N*MW-N){1'b0}}, {N{1'b1}}});
      chk("rst_match_trigger", {{(N*MW-N){1'b0}}, bus.match_trigger}, '0);
      chk("rst_miss_trigger", {{(N*MW-N){1'b0}}, bus.miss_trigger}, '0);
      chk("rst_match_time", bus.match_time, '0);
   endtask

   // Drive one cycle of inputs, predict the outputs after the coming edge, then advance.
   task automatic step(input int st, input logic [N-1:0] nd, input logic [N-1:0] vld,
                       input logic [N*TW-1:0] link);
      ev_t  e;
      cyc_t c;
      int   d;
      int   lk;
      bus.song_time      = TW'(st);
      bus.NDATA          = nd;
      bus.metadata_valid = vld;
      bus.metadata_link  = link;
      for (int ch = 0; ch < N; ch++) begin
         lk = int'(link[ch*TW +: TW]);
         d  = st - exp_t[ch];
         if (mode[ch] == 0) begin
            if (vld[ch]) begin
               if (lk == 65535) mode[ch] = 2;
               else begin exp_t[ch] = lk; mode[ch] = 1; end
            end
         end else if (mode[ch] == 1) begin
            if (nd[ch] && !prev[ch] && d >= -W && d <= W) begin
               mt[ch] = d; mode[ch] = 0;
               e.cyc = edge_no + 1; e.ch = ch; e.is_miss = 1'b0; ev_q.push_back(e);
            end
`ifdef NOTE_MATCH_MISS_EN
            else if (d > W) begin
               mode[ch] = 0;
               e.cyc = edge_no + 1; e.ch = ch; e.is_miss = 1'b1; ev_q.push_back(e);
            end
`endif
         end
         prev[ch] = nd[ch];
      end
      c.cyc = edge_no + 1;
      for (int ch = 0; ch < N; ch++) begin
         c.req[ch] = (mode[ch] == 0);
         c.mtime[ch*MW +: MW] = MW'(mt[ch]);
      end
      cyc_q.push_back(c);
      @(posedge clk);
      #1;
   endtask

   // Monitor: consumes one per-cycle record and any pulses the DUT presents.
   cyc_t m_c;
   ev_t  m_e;
   initial begin
      forever begin
         @(negedge clk);
         if (cyc_q.size() > 0 && cyc_q[0].cyc == edge_no) begin
            m_c = cyc_q.pop_front();
            chk("request", {{(N*MW-N){1'b0}}, bus.metadata_request}, {{(N*MW-N){1'b0}}, m_c.req});
            chk("match_time", bus.match_time, m_c.mtime);
            for (int ch = 0; ch < N; ch++) begin
               if (bus.match_trigger[ch] || bus.miss_trigger[ch]) begin
                  n_cmp++;
                  if (ev_q.size() == 0 || ev_q[0].cyc != edge_no) begin
                     n_bad++;
                     $display("FAIL unexpected_pulse cyc=%0d ch=%0d got hit=%b miss=%b want none",
                              edge_no, ch, bus.match_trigger[ch], bus.miss_trigger[ch]);
                  end else begin
                     m_e = ev_q.pop_front();
                     if (m_e.ch != ch || m_e.is_miss != bus.miss_trigger[ch] ||
                         (bus.match_trigger[ch] && bus.miss_trigger[ch])) begin
                        n_bad++;
                        $display("FAIL pulse cyc=%0d got ch=%0d hit=%b miss=%b want ch=%0d miss=%b",
                                 edge_no, ch, bus.match_trigger[ch], bus.miss_trigger[ch],
                                 m_e.ch, m_e.is_miss);
                     end
                  end
               end
            end
            while (ev_q.size() > 0 && ev_q[0].cyc <= edge_no) begin
               m_e = ev_q.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_pulse cyc=%0d got none want ch=%0d miss=%b",
                        edge_no, m_e.ch, m_e.is_miss);
            end
         end
      end
   end

   logic [N-1:0]    nd, vv, cur_nd;
   logic [N*TW-1:0] lv;
   int              st_r;

   task automatic mid_reset();
      reset = 1'b1;
      #1;
      check_reset_outputs();
      cyc_q.delete();
      ev_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.song_time      = '0;
      bus.NDATA          = '0;
      bus.metadata_valid = '0;
      bus.metadata_link  = '0;
      model_reset();
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int st = 8; st <= 31; st++) begin
         nd = '0; vv = '0; lv = '0;
         if (st == 8) begin
            vv[0] = 1'b1; lv[0*TW +: TW] = 16'd15;
            vv[1] = 1'b1; lv[1*TW +: TW] = 16'd60;
            vv[3] = 1'b1; lv[3*TW +: TW] = 16'd20;
            vv[4] = 1'b1; lv[4*TW +: TW] = 16'd20;
         end
         if (st == 14 || st == 15 || (st >= 17 && st <= 26) || st == 28) nd[0] = 1'b1;
         if (st == 15) begin vv[0] = 1'b1; lv[0*TW +: TW] = 16'd26; end
         if (st == 20) begin nd[3] = 1'b1; nd[4] = 1'b1; end
         if (st == 21) begin
            vv[4] = 1'b1; lv[4*TW +: TW] = 16'hFFFF;
            vv[3] = 1'b1; lv[3*TW +: TW] = 16'd25;
         end
         if (st == 29) begin vv[2] = 1'b1; lv[2*TW +: TW] = 16'd31; nd[2] = 1'b1; end
         if (st == 30) nd[2] = 1'b1;
         step(st, nd, vv, lv);
      end

      mid_reset();

      st_r   = 40;
      cur_nd = '0;
      for (int i = 0; i < 1400; i++) begin
         if (i == 700) mid_reset();
         if ($urandom_range(0, 3) != 0) st_r++;
         vv = '0; lv = '0;
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, 4) == 0) cur_nd[ch] = ~cur_nd[ch];
            if ($urandom_range(0, 3) == 0) begin
               vv[ch] = 1'b1;
               if ($urandom_range(0, 49) == 0) lv[ch*TW +: TW] = 16'hFFFF;
               else lv[ch*TW +: TW] = TW'(st_r + int'($urandom_range(0, 8)));
            end
         end
         step(st_r, cur_nd, vv, lv);
      end

      @(negedge clk);
      @(negedge clk);
      if (ev_q.size() != 0 || cyc_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover got ev=%0d cyc=%0d pending want 0", ev_q.size(), cyc_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/note_match_array.md
# note_match_array

Parametrised, per-note timing matcher for the game core. It sits between the note-detection front end (`NDATA`) and the score/feedback logic. Each of `NUM_NOTES` channels fetches its next expected hit time from the song-metadata store through a request/valid handshake, then grades the next detected note onset against the running `song_time` inside a ±`WINDOW` tolerance. It reports a hit pulse with signed timing error, or optionally a miss pulse, and then fetches the following note.

## Interface
- `NUM_NOTES`, 37, channel count (one per playable pitch).
- `TIME_W`, 16, width of `song_time` and of each metadata time.
- `WINDOW`, 2, hit tolerance in song-time ticks (inclusive).
- `clk` input 1, system clock.
- `reset` input 1, asynchronous, active-high reset.
- `song_time` input TIME_W, running song time; monotonic, never wraps during a song.
- `NDATA` input NUM_NOTES, level per note, high while the note is detected.
- `metadata_link` input NUM_NOTES*TIME_W, slice i is channel i's next expected time; only sampled on ack.
- `metadata_valid` input NUM_NOTES, one-cycle ack for channel i; qualifies slice i.
- `metadata_request` output NUM_NOTES, level: channel i is waiting for metadata.
- `match_trigger` output NUM_NOTES, one-cycle hit pulse.
- `match_time` output NUM_NOTES*(TIME_W+1), slice i is signed two's-complement `song_time - expected`, latched at hit.
- `miss_trigger` output NUM_NOTES, one-cycle miss pulse (0 when miss feature absent).

## Operation
- Channel FSM states:
  - FETCH: `metadata_request` = 1.
  - ARMED: holds the expected time.
  - DONE: end of song for that channel.
- FETCH transitions:
  - `metadata_valid[i]` with slice = all-ones (end-of-song marker) → DONE.
  - `metadata_valid[i]` with any other value → latch the slice, go to ARMED.
  - `metadata_valid` outside FETCH is ignored.
- Onset detection:
  - Onset = rising edge of `NDATA[i]`, i.e. registered previous value 0 and current value 1.
  - A held level yields one onset only.
- Timing error:
  - `delta = {0,song_time} - {0,expected}`, computed in TIME_W+1 bits.
  - Hit iff −WINDOW ≤ delta ≤ WINDOW.
- ARMED with onset and hit:
  - `match_trigger` pulse.
  - `match_time` slice ← delta.
  - Go to FETCH.
- ARMED with onset outside the window: ignored, stay ARMED.
- Onsets in FETCH or DONE are ignored.
- Miss, with `NOTE_MATCH_MISS_EN` only:
  - Condition: ARMED and delta > WINDOW.
  - Action: `miss_trigger` pulse, go to FETCH.
  - Hit and miss cannot coincide; if both are evaluated true through a bug, hit has priority.
- Channels are fully independent. Any number may hit or miss in the same cycle.

## Timing
- Reset values:
  - All channels in FETCH.
  - `metadata_request` = all-ones. Requests are visible during reset and in the first cycle after it.
  - `match_trigger` = 0, `miss_trigger` = 0, `match_time` = 0.
  - Edge-detect registers = 0, so a note already held at reset release counts as an onset.
- Latency:
  - Onset sampled in cycle n → `match_trigger` and `match_time` registered, visible in cycle n+1.
  - `metadata_request` rises in that same cycle n+1.
- Handshake:
  - Ack in cycle n → `metadata_request` low in cycle n+1, channel ARMED in cycle n+1.
  - An onset in the ack cycle is evaluated as "not armed" and dropped.
- `match_time` holds its value until the next hit on that channel.
- A reset asserted mid-operation forces the reset state asynchronously. Partial handshakes are abandoned.

## Configuration
- `NOTE_MATCH_MISS_EN` defined:
  - Miss comparator and `miss_trigger` logic are present.
  - Missed notes advance the channel.
- Not defined:
  - `miss_trigger` is tied to 0.
  - A channel stays ARMED until hit; a missed note blocks that channel.

## Structure
- Package `note_match_pkg`:
  - Channel state enum (FETCH, ARMED, DONE).
  - Default TIME_W and WINDOW.
  - End-of-song marker constant (all-ones).
- Sub-module `note_match_channel`:
  - Contains one FSM, edge detector and comparator.
  - Generated NUM_NOTES times.
  - The top only slices buses.

## Test plan
Defaults for all scenarios: NUM_NOTES=37, TIME_W=16, WINDOW=2.
- Reset, then deassert → all 37 requests high. Ack ch0 with 15 → `metadata_request[0]` low next cycle, other requests stay high.
- ch0 ARMED at 15, `NDATA[0]` rises at `song_time` 14 → one-cycle `match_trigger[0]`, `match_time[16:0]` = 0x1FFFF (−1), `metadata_request[0]` high.
- ch0 ARMED at 15, onset at 9, then held high through 15 → no trigger. Re-press at 17 → hit, delta = +2.
- ch3 ARMED at 20, no onset:
  - With macro: `miss_trigger[3]` pulses when `song_time` = 23, then request rises.
  - Without macro: no pulse, ch3 remains ARMED.
- ch3 and ch4 both ARMED at 20, `NDATA` = 0x18 at 20 → both triggers pulse in the same cycle, both deltas 0. Ack ch4 with 0xFFFF → DONE, no further requests from ch4.
- Assert reset while ch0 is in FETCH and ch1 is ARMED → all outputs return to reset values immediately. Both channels request again after release.
